piso_serializer: RTL and testbench

//  - Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake.
//  - Drives the word out one bit per clk on sout, framed by sout_valid/sout_last.
//  - Transmit end of the single-bit flop-captured stream used by the dff-based capture benches.
//  - Sits between a word-producing stimulus/driver and any serial sink sampling on clk.

---
 rtl/piso_serializer_pkg.sv | 16 +
 rtl/piso_serializer_if.sv | 24 ++
 rtl/piso_serializer_frame_bit_counter.sv | 28 ++
 rtl/piso_serializer.sv | 134 +++++++++++++
 tb/tb_piso_serializer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared state encoding and frame-length helper for the PISO serializer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional even-parity bit is enabled by defining PISO_PARITY_EN.
package piso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_t;

  function automatic int frame_len(int w);
`ifdef PISO_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out handshake bundle for the PISO serializer.
// Latency: n/a (wires only). Backpressure: din_ready gates din_valid.
// The master modport is the word producer and serial observer; the slave modport is the serializer.
interface piso_serializer_if #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_last, busy
  );

endinterface

// File: rtl/piso_serializer_frame_bit_counter.sv
// Bit position counter within a serial frame; saturates at last_idx.
// Latency: cnt updates on the edge after clear/inc. Backpressure: none.
// at_last is combinational from the registered count.
module frame_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  input  logic [CW-1:0] last_idx,
  output logic [CW-1:0] cnt,
  output logic          at_last
);

  assign at_last = (cnt == last_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !at_last) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter; PISO_PARITY_EN appends an even-parity bit.
// Latency: first bit 1 cycle after accept, WIDTH (+1 parity) cycles per frame.
// Backpressure: din_ready only in IDLE or on the last frame bit, allowing zero-gap back-to-back frames.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             load;
  logic             shift;
  logic             at_last;
  logic [CW-1:0]    cnt;
  logic             unused_cnt;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  // The counter value itself is only needed through at_last.
  assign unused_cnt = ^cnt;

`ifdef PISO_PARITY_EN
  assign bus.sout_last = (state == PARITY);
`else
  assign bus.sout_last = (state == SHIFT) && at_last;
`endif

  assign bus.din_ready  = rst && ((state == IDLE) || bus.sout_last);
  assign accept         = bus.din_valid && bus.din_ready;
  assign bus.sout_valid = (state != IDLE);
  assign bus.busy       = (state != IDLE);

  always_comb begin
    bus.sout = 1'b0;
    if (state == SHIFT) begin
      bus.sout = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    end
`ifdef PISO_PARITY_EN
    else if (state == PARITY) begin
      bus.sout = par;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          shift = 1'b1;
        end else begin
`ifdef PISO_PARITY_EN
          state_nxt = PARITY;
`else
          // Reloading on the last bit keeps the serial stream gap-free.
          if (accept) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (accept) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= bus.din;
    end else if (shift) begin
      shreg <= (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^bus.din;
    end
  end
`endif

  frame_bit_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (load),
    .inc      (shift),
    .last_idx (CW'(WIDTH - 1)),
    .cnt      (cnt),
    .at_last  (at_last)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: reset, single frames, back-to-back, busy-ignore, mid-frame reset.
// Observed vector per cycle is {sout_valid, sout, sout_last, din_ready, busy}.
`timescale 1ns/1ps
module tb_piso_serializer;
  import piso_pkg::*;

`ifdef PISO_PARITY_EN
  localparam int MSBF = 0;
`else
  localparam int MSBF = 1;
`endif
  localparam int FL = frame_len(8);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) bus ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(MSBF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic exp_bit(input logic [7:0] w, input int i);
    if (i > 8) return ^w;
    return (MSBF != 0) ? w[8-i] : w[i-1];
  endfunction

  function automatic logic [4:0] obs();
    return {bus.sout_valid, bus.sout, bus.sout_last, bus.din_ready, bus.busy};
  endfunction

  task automatic start_frame(input logic [7:0] w);
    bus.din       = w;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] o;
    bus.din       = 8'hA5;
    bus.din_valid = 1'b1;
    rst           = 1'b0;
    #12;
    o = obs();
    tests++;
    if (o !== 5'b00000) begin
      fails++;
      $display("FAIL reset_hold: got %b expected %b", o, 5'b00000);
    end
    #5 rst = 1'b1;
    #1;
    o = obs();
    tests++;
    if (o !== 5'b00010) begin
      fails++;
      $display("FAIL reset_release: got %b expected %b", o, 5'b00010);
    end
    #1 bus.din_valid = 1'b0;
    @(negedge clk);
    o = obs();
    tests++;
    if (o !== 5'b00010) begin
      fails++;
      $display("FAIL reset_idle: got %b expected %b", o, 5'b00010);
    end
  endtask

  task automatic test_frame(input logic [7:0] w, input string nm);
    logic [4:0] o, e;
    start_frame(w);
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      e = {1'b1, exp_bit(w, i), i == FL, i == FL, 1'b1};
      o = obs();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got %b expected %b", nm, i, o, e);
      end
    end
    @(negedge clk);
    o = obs();
    tests++;
    if (o !== 5'b00010) begin
      fails++;
      $display("FAIL %s idle: got %b expected %b", nm, o, 5'b00010);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] o, e;
    logic [7:0] w;
    int k;
    bus.din       = 8'hFF;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1 bus.din = 8'h00;
    for (int i = 1; i <= 2*FL; i++) begin
      @(negedge clk);
      k = (i <= FL) ? i : i - FL;
      w = (i <= FL) ? 8'hFF : 8'h00;
      e = {1'b1, exp_bit(w, k), k == FL, k == FL, 1'b1};
      o = obs();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", i, o, e);
      end
      if (i == FL) begin
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
      end
    end
    @(negedge clk);
    o = obs();
    tests++;
    if (o !== 5'b00010) begin
      fails++;
      $display("FAIL back_to_back idle: got %b expected %b", o, 5'b00010);
    end
  endtask

  task automatic test_busy_ignore();
    logic [4:0] o, e;
    logic [7:0] w;
    int k;
    start_frame(8'hA5);
    for (int i = 1; i <= 2*FL; i++) begin
      @(negedge clk);
      k = (i <= FL) ? i : i - FL;
      w = (i <= FL) ? 8'hA5 : 8'h3C;
      e = {1'b1, exp_bit(w, k), k == FL, k == FL, 1'b1};
      o = obs();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL busy_ignore cycle %0d: got %b expected %b", i, o, e);
      end
      if (i == 4) begin
        bus.din       = 8'h3C;
        bus.din_valid = 1'b1;
      end
      if (i == FL) begin
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
      end
    end
    @(negedge clk);
    o = obs();
    tests++;
    if (o !== 5'b00010) begin
      fails++;
      $display("FAIL busy_ignore idle: got %b expected %b", o, 5'b00010);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] o, e;
    start_frame(8'hA5);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      e = {1'b1, exp_bit(8'hA5, i), 1'b0, 1'b0, 1'b1};
      o = obs();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL mid_reset cycle %0d: got %b expected %b", i, o, e);
      end
    end
    rst = 1'b0;
    #1;
    o = obs();
    tests++;
    if (o !== 5'b00000) begin
      fails++;
      $display("FAIL mid_reset async: got %b expected %b", o, 5'b00000);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      o = obs();
      tests++;
      if (o !== 5'b00010) begin
        fails++;
        $display("FAIL mid_reset resume %0d: got %b expected %b", i, o, 5'b00010);
      end
      @(negedge clk);
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [8:0] seq;
    logic [4:0] o, e;
    seq = 9'b1_0000_0111;
    start_frame(8'h07);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      e = {1'b1, seq[i-1], i == 9, i == 9, 1'b1};
      o = obs();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL parity cycle %0d: got %b expected %b", i, o, e);
      end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    test_reset();
    test_frame(8'hA5, "frame_a5");
    test_frame(8'h81, "frame_81");
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_frame(8'h5A, "frame_post_reset");
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
